jts16_obj_ram_ctrl: RTL and testbench

JTS16_OBJ_RAM_CTRL -- requirements
Module: jts16_obj_ram_ctrl

---
 rtl/jts16_obj_ram_ctrl_pkg.sv | 28 ++
 rtl/jts16_obj_copy.sv | 80 ++++++++
 rtl/jts16_obj_ram_ctrl.sv | 102 ++++++++++
 tb/tb_jts16_obj_ram_ctrl.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jts16_obj_ram_ctrl_pkg.sv
// Shared constants, FSM encodings and the display-port request bundle for the
// object RAM controller and its copy engine.
package jts16_obj_ram_ctrl_pkg;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;
  localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_ACC  = 2'd1,
    C_DATA = 2'd2,
    C_DONE = 2'd3
  } cpu_st_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_RD   = 2'd1,
    P_WR   = 2'd2
  } copy_st_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   din;
    logic          we;
  } disp_req_t;

endpackage

// File: rtl/jts16_obj_copy.sv
// Live-to-display copy engine: on a qualified vblank rising edge, copies all
// words of the live object RAM into the display RAM, one word per two cycles.
module jts16_obj_copy
  import jts16_obj_ram_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vblank,
  input  logic          swap_en,
  input  logic          cpu_acc,
  input  logic          scan_act,
  input  logic [15:0]   live_dout,
  output logic [AW-1:0] live_addr,
  output disp_req_t     disp_req,
  output logic          copy_busy,
  output logic          frame_done
);

  copy_st_e      st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          vblank_q, vblank_d;
  logic          frame_done_q, frame_done_d;
  logic          vb_rise;

  assign vb_rise = vblank & ~vblank_q;

  always_comb begin
    st_d          = st_q;
    cnt_d         = cnt_q;
    vblank_d      = vblank;
    frame_done_d  = 1'b0;
    disp_req.addr = cnt_q;
    disp_req.din  = live_dout;
    disp_req.we   = 1'b0;
    case (st_q)
      P_IDLE: if (vb_rise && swap_en) begin
        st_d  = P_RD;
        cnt_d = '0;
      end
      // The read address is on the live port whenever we are in P_RD; it only
      // counts as issued when the CPU is not taking the port this cycle.
      P_RD: if (!cpu_acc && !scan_act) st_d = P_WR;
      P_WR: begin
        if (scan_act) begin
          st_d = P_RD;
        end else begin
          disp_req.we = rst_n;
          if (cnt_q == LAST_WORD) begin
            st_d         = P_IDLE;
            frame_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            st_d  = P_RD;
          end
        end
      end
      default: st_d = P_IDLE;
    endcase
  end

  // vblank_q resets high so a vblank already asserted at release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q         <= P_IDLE;
      cnt_q        <= '0;
      vblank_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      vblank_q     <= vblank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign live_addr  = cnt_q;
  assign copy_busy  = (st_q != P_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: rtl/jts16_obj_ram_ctrl.sv
// Object RAM controller: CPU access FSM on the live RAM, display RAM port
// arbitration between the scanner and the live-to-display copy engine.
module jts16_obj_ram_ctrl
  import jts16_obj_ram_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vblank,
  input  logic          swap_en,
  input  logic          cpu_cs,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_din,
  input  logic [1:0]    cpu_dsn,
  output logic [15:0]   cpu_dout,
  output logic          cpu_ok,
  output logic [AW-1:0] live_addr,
  output logic [15:0]   live_din,
  output logic [1:0]    live_we,
  input  logic [15:0]   live_dout,
  input  logic [AW-1:0] scan_addr,
  input  logic [15:0]   scan_din,
  input  logic          scan_we,
  input  logic          scan_act,
  output logic [15:0]   scan_dout,
  output logic [AW-1:0] disp_addr,
  output logic [15:0]   disp_din,
  output logic          disp_we,
  input  logic [15:0]   disp_dout,
  output logic          copy_busy,
  output logic          frame_done
);

  cpu_st_e       cst_q, cst_d;
  logic [15:0]   cpu_dout_q, cpu_dout_d;
  logic          cpu_acc;
  logic [AW-1:0] copy_addr;
  disp_req_t     copy_req;
  logic          copy_own;

  assign cpu_acc  = (cst_q == C_ACC);
  assign cpu_ok   = (cst_q == C_DONE);
  assign cpu_dout = cpu_dout_q;

  always_comb begin
    cst_d      = cst_q;
    cpu_dout_d = cpu_dout_q;
    case (cst_q)
      C_IDLE: if (cpu_cs && !cpu_ok) cst_d = C_ACC;
      C_ACC:  cst_d = C_DATA;
      C_DATA: begin
        if (cpu_rnw) cpu_dout_d = live_dout;
        cst_d = C_DONE;
      end
      C_DONE: if (!cpu_cs) cst_d = C_IDLE;
      default: cst_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cst_q      <= C_IDLE;
      cpu_dout_q <= '0;
    end else begin
      cst_q      <= cst_d;
      cpu_dout_q <= cpu_dout_d;
    end
  end

  // Live port: CPU always wins; otherwise the copy engine's read address.
  always_comb begin
    live_addr = copy_addr;
    live_din  = cpu_din;
    live_we   = 2'b00;
    if (cpu_acc) begin
      live_addr = cpu_addr;
      if (!cpu_rnw && rst_n) live_we = ~cpu_dsn;
    end
  end

  jts16_obj_copy u_copy (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblank     (vblank),
    .swap_en    (swap_en),
    .cpu_acc    (cpu_acc),
    .scan_act   (scan_act),
    .live_dout  (live_dout),
    .live_addr  (copy_addr),
    .disp_req   (copy_req),
    .copy_busy  (copy_busy),
    .frame_done (frame_done)
  );

  // Scanner keeps the display port whenever it is active.
  assign copy_own  = copy_busy & ~scan_act;
  assign disp_addr = copy_own ? copy_req.addr : scan_addr;
  assign disp_din  = copy_own ? copy_req.din  : scan_din;
  assign disp_we   = copy_own ? copy_req.we   : scan_we;
  assign scan_dout = disp_dout;

endmodule

// File: tb/tb_jts16_obj_ram_ctrl.sv
// Self-checking bench for jts16_obj_ram_ctrl with live/display RAM models and
// a word-level reference of the live RAM contents.
module tb_jts16_obj_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, vblank, swap_en;
  logic        cpu_cs, cpu_rnw;
  logic [9:0]  cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_dsn;
  logic [15:0] cpu_dout;
  logic        cpu_ok;
  logic [9:0]  live_addr;
  logic [15:0] live_din;
  logic [1:0]  live_we;
  logic [15:0] live_dout;
  logic [9:0]  scan_addr;
  logic [15:0] scan_din;
  logic        scan_we, scan_act;
  logic [15:0] scan_dout;
  logic [9:0]  disp_addr;
  logic [15:0] disp_din;
  logic        disp_we;
  logic [15:0] disp_dout;
  logic        copy_busy, frame_done;

  logic [15:0] live_mem [1024];
  logic [15:0] disp_mem [1024];
  logic [15:0] ref_live [1024];
  logic [15:0] exp_disp [1024];
  logic        bd_we = 1'b0;
  logic [9:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, rd_cyc = 0, fd_cyc = 0, fd_cnt = 0, busy_rises = 0;
  int scan_viol = 0, rst_viol = 0, fd_wide = 0;
  logic busy_prev = 1'b0, fd_prev = 1'b0;

  jts16_obj_ram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vblank(vblank), .swap_en(swap_en),
    .cpu_cs(cpu_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dsn(cpu_dsn), .cpu_dout(cpu_dout), .cpu_ok(cpu_ok),
    .live_addr(live_addr), .live_din(live_din), .live_we(live_we), .live_dout(live_dout),
    .scan_addr(scan_addr), .scan_din(scan_din), .scan_we(scan_we), .scan_act(scan_act),
    .scan_dout(scan_dout), .disp_addr(disp_addr), .disp_din(disp_din), .disp_we(disp_we),
    .disp_dout(disp_dout), .copy_busy(copy_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // RAM models: byte-write live RAM with a backdoor fill port, word-write display RAM.
  always @(posedge clk) begin
    if (bd_we) live_mem[bd_addr] <= bd_data;
    else begin
      if (live_we[1]) live_mem[live_addr][15:8] <= live_din[15:8];
      if (live_we[0]) live_mem[live_addr][7:0]  <= live_din[7:0];
    end
    live_dout <= live_mem[live_addr];
    if (disp_we) disp_mem[disp_addr] <= disp_din;
    disp_dout <= disp_mem[disp_addr];
  end

  always @(negedge clk) begin
    cyc++;
    if (copy_busy && !busy_prev) begin busy_rises++; rd_cyc = cyc; end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (frame_done && fd_prev) fd_wide++;
    if ((scan_act || !copy_busy) &&
        (disp_we !== scan_we || disp_addr !== scan_addr || disp_din !== scan_din)) scan_viol++;
    if (scan_dout !== disp_dout) scan_viol++;
    if (!rst_n && (disp_we !== 1'b0 || live_we !== 2'b00)) rst_viol++;
    busy_prev = copy_busy;
    fd_prev   = frame_done;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fill(input bit rnd);
    for (int a = 0; a < 1024; a++) begin
      bd_we   = 1'b1;
      bd_addr = 10'(a);
      bd_data = rnd ? 16'($urandom) : (16'(a) ^ 16'h5A5A);
      ref_live[a] = bd_data;
      tick();
    end
    bd_we = 1'b0;
  endtask

  task automatic snap_expected();
    for (int a = 0; a < 1024; a++) exp_disp[a] = ref_live[a];
  endtask

  task automatic cpu_access(input bit rnw, input logic [9:0] addr, input logic [15:0] din,
                            input logic [1:0] dsn, output logic [15:0] dout, output int lat,
                            output int we_cycles, output logic [1:0] we_seen);
    cpu_rnw = rnw; cpu_addr = addr; cpu_din = din; cpu_dsn = dsn; cpu_cs = 1'b1;
    lat = 0; we_cycles = 0; we_seen = 2'b00;
    while (cpu_ok !== 1'b1 && lat < 20) begin
      tick(); lat++;
      if (live_we !== 2'b00) begin we_cycles++; we_seen = live_we; end
    end
    dout = cpu_dout;
    cpu_cs = 1'b0;
    tick();
    if (!rnw) begin
      if (!dsn[1]) ref_live[addr][15:8] = din[15:8];
      if (!dsn[0]) ref_live[addr][7:0]  = din[7:0];
    end
  endtask

  task automatic start_copy(output bit ok);
    int n, r0;
    r0 = busy_rises; n = 0;
    vblank = 1'b1;
    while (busy_rises == r0 && n < 8) begin tick(); n++; end
    ok = (busy_rises != r0);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n, f0;
    f0 = fd_cnt; n = 0;
    while (fd_cnt == f0 && n < budget) begin tick(); n++; end
    ok = (fd_cnt != f0);
  endtask

  task automatic check_disp(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int a = 0; a < 1024; a++)
      if (disp_mem[a] !== exp_disp[a]) begin bad++; if (first < 0) first = a; end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d display words wrong, first at %0d got %h expected %h",
               name, bad, first, disp_mem[first], exp_disp[first]);
    end
  endtask

  task automatic check_copy_run(input string name, input bit ok, input int min_len, input int max_len);
    int len;
    len = fd_cyc - rd_cyc;
    n_chk++;
    if (!ok || len < min_len || len > max_len) begin
      n_fail++;
      $display("FAIL %s: copy done=%0d length %0d expected %0d..%0d", name, ok, len, min_len, max_len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vblank = 1'b1; swap_en = 1'b1;
    cpu_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_din = '0; cpu_dsn = 2'b11;
    scan_addr = '0; scan_din = '0; scan_we = 1'b0; scan_act = 1'b0;
    ticks(3);
    n_chk++;
    if (cpu_ok !== 1'b0 || cpu_dout !== 16'h0 || copy_busy !== 1'b0 ||
        frame_done !== 1'b0 || live_we !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: ok=%b dout=%h busy=%b fd=%b we=%b expected all zero",
               cpu_ok, cpu_dout, copy_busy, frame_done, live_we);
    end
    rst_n = 1'b1;
    ticks(10);
    n_chk++;
    if (copy_busy !== 1'b0 || busy_rises != 0) begin
      n_fail++;
      $display("FAIL reset_vblank_high: busy=%b starts=%0d expected 0 0", copy_busy, busy_rises);
    end
    vblank = 1'b0;
    ticks(2);
  endtask

  task automatic test_cpu_basic();
    logic [15:0] d; int lat, wc; logic [1:0] ws; logic [9:0] a; bit rnw; logic [1:0] dsn;
    logic [15:0] din, expv;
    fill(1'b1);
    cpu_access(1'b0, 10'h005, 16'h1234, 2'b01, d, lat, wc, ws);
    n_chk++;
    if (lat != 3 || wc != 1 || ws !== 2'b10) begin
      n_fail++;
      $display("FAIL cpu_write: lat=%0d we_cycles=%0d we=%b expected 3 1 10", lat, wc, ws);
    end
    cpu_access(1'b1, 10'h005, 16'h0, 2'b00, d, lat, wc, ws);
    n_chk++;
    if (lat != 3 || d[15:8] !== 8'h12 || d !== ref_live[5] || wc != 0) begin
      n_fail++;
      $display("FAIL cpu_readback: lat=%0d data=%h expected 3 %h", lat, d, ref_live[5]);
    end
    for (int i = 0; i < 16; i++) begin
      rnw = 1'($urandom_range(0, 1)); a = 10'($urandom); din = 16'($urandom);
      dsn = 2'($urandom_range(0, 2));
      expv = ref_live[a];
      cpu_access(rnw, a, din, dsn, d, lat, wc, ws);
      n_chk++;
      if (lat != 3 || (rnw && d !== expv) || (!rnw && (wc != 1 || ws !== ~dsn))) begin
        n_fail++;
        $display("FAIL cpu_random: rnw=%b addr=%h lat=%0d data=%h we=%b expected lat 3 data %h we %b",
                 rnw, a, lat, d, ws, expv, ~dsn);
      end
    end
  endtask

  task automatic test_copy_basic();
    bit ok;
    swap_en = 1'b1;
    fill(1'b0);
    snap_expected();
    start_copy(ok);
    vblank = 1'b0;
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL copy_start: busy=%b expected 1", copy_busy); end
    wait_done(5000, ok);
    check_copy_run("copy_length", ok, 2048, 2048);
    n_chk++;
    if (frame_done !== 1'b0 || copy_busy !== 1'b0 || fd_wide != 0) begin
      n_fail++;
      $display("FAIL copy_end: fd=%b busy=%b wide=%0d expected 0 0 0", frame_done, copy_busy, fd_wide);
    end
    check_disp("copy_pattern");
  endtask

  task automatic test_scan_passthrough();
    logic [9:0] a; logic [15:0] dv; logic [15:0] expv;
    for (int i = 0; i < 6; i++) begin
      a = 10'($urandom); dv = 16'($urandom);
      scan_addr = a; scan_din = dv; scan_we = 1'b1; scan_act = 1'($urandom_range(0, 1));
      #1;
      n_chk++;
      if (disp_addr !== a || disp_din !== dv || disp_we !== 1'b1) begin
        n_fail++;
        $display("FAIL scan_pass: addr=%h din=%h we=%b expected %h %h 1", disp_addr, disp_din, disp_we, a, dv);
      end
      tick();
      exp_disp[a] = dv;
      scan_we = 1'b0;
      expv = exp_disp[scan_addr];
      tick();
      n_chk++;
      if (scan_dout !== expv) begin
        n_fail++;
        $display("FAIL scan_read: data=%h expected %h", scan_dout, expv);
      end
    end
    scan_act = 1'b0;
    tick();
  endtask

  task automatic test_cpu_during_copy();
    bit ok; logic [15:0] d, expv, w0, w1; int lat, wc, f0, rd_bad, it; logic [1:0] ws; logic [9:0] a;
    fill(1'b1);
    snap_expected();
    f0 = fd_cnt;
    start_copy(ok);
    vblank = 1'b0;
    rd_bad = 0;
    for (int i = 0; i < 5; i++) begin
      a = 10'($urandom); expv = ref_live[a];
      cpu_access(1'b1, a, 16'h0, 2'b00, d, lat, wc, ws);
      if (d !== expv || lat != 3) rd_bad++;
    end
    w0 = 16'($urandom); w1 = 16'($urandom);
    cpu_access(1'b0, 10'd0, w0, 2'b00, d, lat, wc, ws);
    cpu_access(1'b0, 10'd1023, w1, 2'b00, d, lat, wc, ws);
    exp_disp[1023] = w1;
    it = 0;
    while (fd_cnt == f0 && it < 2000) begin
      a = 10'($urandom); expv = ref_live[a];
      cpu_access(1'b1, a, 16'h0, 2'b00, d, lat, wc, ws);
      if (d !== expv || lat != 3) rd_bad++;
      it++;
    end
    n_chk++;
    if (rd_bad != 0) begin n_fail++; $display("FAIL cpu_reads_in_copy: %0d bad reads expected 0", rd_bad); end
    check_copy_run("copy_with_cpu", ok && fd_cnt == f0 + 1, 2049, 20000);
    check_disp("copy_with_cpu_data");
  endtask

  task automatic test_scan_pause();
    bit ok; int v0;
    fill(1'b1);
    snap_expected();
    v0 = scan_viol;
    start_copy(ok);
    vblank = 1'b0;
    ticks(300);
    scan_act = 1'b1; scan_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      scan_addr = 10'($urandom); scan_din = 16'($urandom);
      tick();
    end
    scan_act = 1'b0;
    wait_done(5000, ok);
    check_copy_run("copy_scan_delay", ok, 2148, 2400);
    n_chk++;
    if (scan_viol != v0) begin
      n_fail++;
      $display("FAIL scan_ownership: %0d port violations expected 0", scan_viol - v0);
    end
    check_disp("copy_scan_data");
  endtask

  task automatic test_vblank_retrigger();
    bit ok; int r0;
    fill(1'b1);
    snap_expected();
    r0 = busy_rises;
    start_copy(ok);
    vblank = 1'b0;
    ticks(200);
    vblank = 1'b1;
    ticks(5);
    swap_en = 1'b0;
    vblank = 1'b0;
    wait_done(5000, ok);
    check_copy_run("copy_no_restart", ok, 2048, 2048);
    ticks(20);
    n_chk++;
    if (busy_rises != r0 + 1 || copy_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL retrigger: starts=%0d busy=%b expected %0d 0", busy_rises - r0, copy_busy, 1);
    end
    check_disp("copy_retrigger_data");
    fill(1'b1);
    vblank = 1'b1;
    ticks(20);
    vblank = 1'b0;
    ticks(5);
    n_chk++;
    if (busy_rises != r0 + 1) begin
      n_fail++;
      $display("FAIL swap_disabled: starts=%0d expected 0", busy_rises - r0 - 1);
    end
    check_disp("swap_disabled_data");
  endtask

  task automatic test_reset_mid_copy();
    bit ok; int f0;
    swap_en = 1'b1;
    fill(1'b1);
    start_copy(ok);
    vblank = 1'b0;
    ticks(998);
    rst_n = 1'b0;
    ticks(2);
    n_chk++;
    if (copy_busy !== 1'b0 || frame_done !== 1'b0 || cpu_ok !== 1'b0 || rst_viol != 0) begin
      n_fail++;
      $display("FAIL reset_mid_copy: busy=%b fd=%b ok=%b writes=%0d expected 0 0 0 0",
               copy_busy, frame_done, cpu_ok, rst_viol);
    end
    rst_n = 1'b1;
    f0 = fd_cnt;
    ticks(2500);
    n_chk++;
    if (fd_cnt != f0 || copy_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abandon: frame_done=%0d busy=%b expected 0 0", fd_cnt - f0, copy_busy);
    end
    fill(1'b1);
    snap_expected();
    start_copy(ok);
    vblank = 1'b0;
    wait_done(5000, ok);
    check_copy_run("copy_after_reset", ok, 2048, 2048);
    check_disp("copy_after_reset_data");
  endtask

  initial begin
    test_reset();
    test_cpu_basic();
    test_copy_basic();
    test_scan_passthrough();
    test_cpu_during_copy();
    test_scan_pause();
    test_vblank_retrigger();
    test_reset_mid_copy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
